// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the PicoRV32 memory responder.
//   state_t   : responder FSM states
//   req_t     : request fields captured at acceptance
//   OOR_RDATA : read value returned for out-of-range addresses
//   WCNT_W    : width of the wait-state counter
package picorv32_mem_pkg;

  localparam int          WCNT_W    = 4;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        instr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        in_range;
  } req_t;

endpackage

// File: rtl/picorv32_mem_sram.sv
// Single-port MEM_WORDS x 32 word array with byte-lane write enables and a
// registered read port.
//   clk, resetn : clock, synchronous active-low reset (read register only)
//   addr        : word index, shared by read and write
//   rd_en       : load rdata from the array at addr
//   rd_clr      : load rdata with the out-of-range value instead
//   we          : per-byte write enables
//   wdata       : write data
//   rdata       : registered read data, holds until the next rd_en/rd_clr
module picorv32_mem_sram
  import picorv32_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Array contents are intentionally not reset.
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!resetn)     rdata <= '0;
    else if (rd_clr) rdata <= OOR_RDATA;
    else if (rd_en)  rdata <= mem[addr];
  end

endmodule

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the PicoRV32 native memory interface.
// Accepts a request, waits WAIT_STATES cycles, then pulses mem_ready for one
// cycle. Reads are served from the internal array at acceptance; writes are
// committed in the response cycle. Out-of-range accesses still complete but
// raise err, return zero and never touch the array.
//   clk, resetn          : clock, synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb : request from the core
//   mem_ready            : one-cycle completion pulse
//   mem_rdata            : read data, valid while mem_ready is high
//   err                  : out-of-range flag, pulses with mem_ready
//   fetch_cnt            : completed in-range instruction fetches (wraps)
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err,
  output logic [31:0] fetch_cnt
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t            state;
  req_t              req;
  logic [WCNT_W-1:0] cnt;
  logic [AW-1:0]     idx_q;

  // BASE_ADDR is aligned to the array size, so a plain byte subtraction
  // followed by >>2 equals the word-address difference. Addresses below the
  // base wrap to large values and fail the range check.
  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] idx_live;

  assign off      = mem_addr - BASE_ADDR;
  assign hit      = (off >> 2) < 32'(MEM_WORDS);
  assign idx_live = AW'(off >> 2);

  logic       accept, resp, is_rd;
  logic [3:0] we;

  assign accept = (state == ST_IDLE) && mem_valid;
  assign resp   = (state == ST_RESP);
  assign is_rd  = (mem_wstrb == 4'b0000);
  // resetn gate: a reset edge coinciding with the write edge wins.
  assign we     = (resp && req.in_range && resetn) ? req.wstrb : 4'b0000;

  picorv32_mem_sram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_sram (
    .clk    (clk),
    .resetn (resetn),
    .addr   (resp ? idx_q : idx_live),
    .rd_en  (accept && is_rd && hit),
    .rd_clr (accept && is_rd && !hit),
    .we     (we),
    .wdata  (req.wdata),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req       <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_ready <= 1'b0;
          err       <= 1'b0;
          if (mem_valid) begin
            req   <= '{instr: mem_instr, wstrb: mem_wstrb,
                       wdata: mem_wdata, in_range: hit};
            idx_q <= idx_live;
            cnt   <= WCNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state     <= ST_RESP;
              mem_ready <= 1'b1;
              err       <= !hit;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Dropping mem_valid here is a protocol violation: abandon quietly.
          if (!mem_valid) begin
            state <= ST_IDLE;
          end else if (cnt == WCNT_W'(1)) begin
            state     <= ST_RESP;
            mem_ready <= 1'b1;
            err       <= !req.in_range;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          mem_ready <= 1'b0;
          err       <= 1'b0;
          if (req.instr && req.in_range) fetch_cnt <= fetch_cnt + 32'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
module tb_picorv32_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // u_dut0: WAIT_STATES=0, u_dut3: WAIT_STATES=3; both 16 words at base 0
  logic        v0, i0, r0, e0, v3, i3, r3, e3;
  logic [31:0] a0, wd0, rd0, fc0, a3, wd3, rd3, fc3;
  logic [3:0]  ws0, ws3;

  picorv32_mem_responder #(.MEM_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_instr(i0), .mem_addr(a0),
    .mem_wdata(wd0), .mem_wstrb(ws0), .mem_ready(r0), .mem_rdata(rd0),
    .err(e0), .fetch_cnt(fc0));

  picorv32_mem_responder #(.MEM_WORDS(16), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk(clk), .resetn(resetn), .mem_valid(v3), .mem_instr(i3), .mem_addr(a3),
    .mem_wdata(wd3), .mem_wstrb(ws3), .mem_ready(r3), .mem_rdata(rd3),
    .err(e3), .fetch_cnt(fc3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins);
    if (s) begin v3 = v; a3 = a; wd3 = wd; ws3 = ws; i3 = ins; end
    else   begin v0 = v; a0 = a; wd0 = wd; ws0 = ws; i0 = ins; end
  endtask

  // One complete transaction on DUT s; returns data, err and latency in cycles
  // counted from the first cycle mem_valid is high.
  task automatic xfer(input bit s, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins,
                      output logic [31:0] rd, output logic er, output int lat);
    @(posedge clk); #1;
    drive(s, 1'b1, a, wd, ws, ins);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(s ? r3 : r0) && lat < 20);
    chk("ready_seen", {31'd0, (s ? r3 : r0)}, 32'd1);
    rd = s ? rd3 : rd0;
    er = s ? e3 : e0;
    drive(s, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("ready_pulse", {31'd0, (s ? r3 : r0)}, 32'd0);
    chk("err_pulse",   {31'd0, (s ? e3 : e0)}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, r0}, 32'd0);
    chk("rst_err0",   {31'd0, e0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_fcnt0",  fc0, 32'd0);
    chk("rst_ready3", {31'd0, r3}, 32'd0);
    chk("rst_rdata3", rd3, 32'd0);
    resetn = 1'b1;

    // zero wait states: write then read back
    xfer(0, 32'h10, 32'hA5A5_1234, 4'hF, 0, rd, er, lat);
    chk("w0_lat", lat, 1);
    chk("w0_err", {31'd0, er}, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("r0_lat", lat, 1);
    chk("r0_data", rd, 32'hA5A5_1234);
    chk("r0_err", {31'd0, er}, 0);
    // a write leaves mem_rdata holding the previous read value
    xfer(0, 32'h14, 32'h0, 4'hF, 0, rd, er, lat);
    chk("w_hold", rd, 32'hA5A5_1234);

    // byte lanes
    xfer(0, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    xfer(0, 32'h20, 32'h0000_0000, 4'b0101, 0, rd, er, lat);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("lanes", rd, 32'hFF00_FF00);

    // out of range just past the last word
    xfer(0, 32'h00, 32'hCAFE_0000, 4'hF, 0, rd, er, lat);
    xfer(0, 32'h3C, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
    xfer(0, 32'h3C, 32'h0, 4'h0, 0, rd, er, lat);
    chk("last_word", rd, 32'h0BAD_F00D);
    chk("last_err", {31'd0, er}, 0);
    xfer(0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rd_err", {31'd0, er}, 1);
    xfer(0, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    chk("oor_wr_err", {31'd0, er}, 1);
    xfer(0, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
    chk("oor_word0", rd, 32'hCAFE_0000);
    xfer(0, 32'h3C, 32'h0, 4'h0, 0, rd, er, lat);
    chk("oor_wordN", rd, 32'h0BAD_F00D);

    // fetch counting
    chk("fcnt_start", fc0, 32'd0);
    for (int k = 0; k < 5; k++) xfer(0, 32'h10, 32'h0, 4'h0, 1, rd, er, lat);
    for (int k = 0; k < 2; k++) xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("fcnt_5", fc0, 32'd5);
    xfer(0, 32'h40, 32'h0, 4'h0, 1, rd, er, lat);
    chk("fcnt_oor_err", {31'd0, er}, 1);
    chk("fcnt_oor", fc0, 32'd5);

    // three wait states
    xfer(1, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
    chk("w3_lat", lat, 4);
    xfer(1, 32'h08, 32'h1111_2222, 4'hF, 0, rd, er, lat);
    chk("w3_wlat", lat, 4);
    xfer(1, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("w3_rdata", rd, 32'h1111_2222);

    // mem_valid dropped mid-WAIT on a write
    @(posedge clk); #1;
    drive(1, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0);
    @(posedge clk);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= r3; end
    chk("abort_noready", {31'd0, seen}, 0);
    xfer(1, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("abort_nowrite", rd, 32'h1111_2222);

    // reset mid-WAIT
    @(posedge clk); #1;
    drive(1, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, 1);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rstw_ready", {31'd0, r3}, 0);
    chk("rstw_err",   {31'd0, e3}, 0);
    chk("rstw_rdata", rd3, 32'h0);
    chk("rstw_fcnt0", fc0, 32'h0);
    resetn = 1'b1;
    xfer(1, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rstw_keep", rd, 32'h1111_2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_responder.md
# picorv32_mem_responder

Memory-side responder for the PicoRV32 native memory interface. It answers `mem_valid` requests from the core with `mem_ready` after a parameterised number of wait states. It serves reads and byte-strobed writes from an internal word-addressed SRAM array. Out-of-range accesses are flagged, and instruction fetches are counted. It replaces free-running `mem_ready` generators in core-level builds, giving a real memory behind the core.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of the word array; a power of two, ≥ 2.
- `WAIT_STATES`, 1: extra cycles between request acceptance and `mem_ready`; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to 4·`MEM_WORDS`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `mem_valid` in 1: request valid from the core.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address; bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high.
- `err` out 1: pulses with `mem_ready` when the address is out of range.
- `fetch_cnt` out 32: count of completed in-range instruction fetches.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With `mem_valid`=1, latch addr/wdata/wstrb/instr and load the wait counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - If `mem_valid` drops (protocol violation), abort to IDLE: no write, no `mem_ready`.
- RESP: `mem_ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- The request is never re-accepted in the RESP cycle. The core either drops `mem_valid` or presents a new request, and IDLE samples that on the next cycle.
- In-range test: `mem_addr[31:2]` minus `BASE_ADDR[31:2]` < `MEM_WORDS`. Index = the low log2(`MEM_WORDS`) bits of that difference.
- Reads (wstrb=0), in range: `mem_rdata` = the array word, registered so it is valid in the RESP cycle.
- Writes, in range: in the RESP cycle, write each byte lane i where `mem_wstrb[i]`=1; other lanes are untouched. `mem_rdata` holds its previous value.
- Out of range:
  - Reads return 32'h0000_0000. Writes are dropped.
  - `err`=1 in the RESP cycle. `mem_ready` still pulses, so the core never hangs.
- `fetch_cnt` increments in RESP when `mem_instr`=1 and the access is in range. It wraps 32'hFFFF_FFFF → 0.

## Timing
- Reset values: state=IDLE, `mem_ready`=0, `err`=0, `mem_rdata`=0, `fetch_cnt`=0. Array contents are not reset.
- Latency from the first cycle `mem_valid` is high to `mem_ready` high is `WAIT_STATES`+1 cycles. With `WAIT_STATES`=0 the latency is 1 cycle, so back-to-back requests complete every 2 cycles.
- Request inputs are sampled only at acceptance. Later changes while in WAIT are ignored; only `mem_valid` is monitored there.
- Reset asserted in WAIT or RESP:
  - Next state is IDLE, with no `mem_ready` and no write.
  - The array is unchanged, unless the write edge coincides with the reset edge; then reset wins and the write is suppressed.
- `mem_ready` and `err` are never high for two consecutive cycles.

## Structure
- Package `picorv32_mem_pkg`:
  - FSM state enum.
  - Out-of-range read value constant (32'h0).
  - Wait-counter width constant (4).
- Sub-module `picorv32_mem_sram`: single-port array of `MEM_WORDS` × 32 with 4 byte-lane write enables and a registered read port. It is read at acceptance and written in RESP.
- Top level: FSM, address decode, counters.

## Test plan
- `WAIT_STATES`=0, write 32'hA5A5_1234 to 0x10 with wstrb=4'hF, then read 0x10 → `mem_ready` 1 cycle after each `mem_valid`, rdata=32'hA5A5_1234, `err`=0.
- `WAIT_STATES`=3, read 0x0 → `mem_ready` exactly 4 cycles after `mem_valid` rises and high for 1 cycle.
- Write 32'hFFFF_FFFF with wstrb=4'hF, then 32'h0000_0000 with wstrb=4'b0101 to 0x20, then read → 32'hFF00_FF00.
- Read at `BASE_ADDR`+4·`MEM_WORDS` → rdata=0 and `err`=1 with `mem_ready`. A write there leaves word 0 and the last word unchanged.
- Drop `mem_valid` mid-WAIT on a write to 0x8 → no `mem_ready`, and a later read of 0x8 returns the old value. Reset asserted mid-WAIT → all outputs at reset values on the next cycle.
- 5 fetches (`mem_instr`=1) and 2 data reads → `fetch_cnt`=5. One out-of-range fetch → still 5.
